game_controller: RTL and testbench
==================================

# game_controller

Match-level state machine for the penalty shoot-out, sitting directly upstream of the screen selector. Turns player inputs (start button, mode switch) and per-kick results from the kick-resolution logic into the `control_if` bundle (`game_state`, `game_mode`, `score`, `round_counter`, `is_scored`). The selector and drawing stages consume that bundle. The block alternates shooter and keeper turns, keeps score, holds each kick result on screen for a fixed time, and decides winner or loser.

## Interface
Parameters:
- `ROUNDS`, default 5: regular rounds; one round is a player kick plus an opponent kick.
- `HOLD_CYCLES`, default 65_000_000: result-display hold in clock cycles (1 s at 65 MHz).

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `rst`  in  1  reset; asynchronous, active-low (low = reset).
- `start_btn`  in  1  debounced start/restart button; level input, rising edge acts.
- `mode_sel`  in  1  0 = SOLO, 1 = MULTI; sampled only on the start edge.
- `shot_done`  in  1  one-cycle pulse: current kick resolved.
- `shot_goal`  in  1  kick outcome, valid with `shot_done`; 1 = goal.
- `out_control`  control_if.out  —  registered outputs:
  - `game_state`: enum START, SHOOTER, KEEPER, WINNER, LOOSER.
  - `game_mode`: MULTI/SOLO.
  - `score`: 8 bits; [7:4] player goals, [3:0] opponent goals.
  - `round_counter`: 4 bits.
  - `is_scored`: 1 bit.

## Operation
- States: START, SHOOTER, KEEPER, WINNER, LOOSER, plus an internal `hold` flag that is valid in SHOOTER/KEEPER.
- Start edge: rising edge of `start_btn`, detected with a 1-cycle delayed copy.
- START:
  - On start edge: go to SHOOTER; `round_counter` = 1; `score` = 0; `is_scored` = 0; `game_mode` = `mode_sel`.
- SHOOTER, not holding:
  - On `shot_done`: `is_scored` = `shot_goal`.
  - If goal, player nibble += 1, saturating at 15.
  - Set `hold`; load hold counter with `HOLD_CYCLES-1`.
- KEEPER, not holding:
  - Same as SHOOTER, except a goal increments the opponent nibble.
- While holding:
  - Counter decrements each cycle.
  - `shot_done` is ignored.
- Hold expiry (counter = 0):
  - Clear `hold` and `is_scored`.
  - From SHOOTER: go to KEEPER.
  - From KEEPER, end of round. With P = player nibble, O = opponent nibble:
    - `round_counter` < `ROUNDS`: `round_counter` += 1; go to SHOOTER.
    - `round_counter` ≥ `ROUNDS` and P > O: go to WINNER.
    - `round_counter` ≥ `ROUNDS` and P < O: go to LOOSER.
    - `round_counter` ≥ `ROUNDS` and P == O: see Configuration.
- WINNER / LOOSER:
  - `score` and `round_counter` are frozen.
  - On start edge: go to START, clearing `score`, `round_counter` and `is_scored`.
- `shot_done` is ignored in START, WINNER and LOOSER.
- `start_btn` is ignored in SHOOTER/KEEPER; a match cannot be aborted except by reset.
- `game_mode` does not change between start edges.

## Timing
- Reset values, applied asynchronously:
  - `game_state` = START, `game_mode` = MULTI.
  - `score` = 0, `round_counter` = 0, `is_scored` = 0.
  - `hold` = 0, hold counter = 0, edge register = 0.
- All outputs are registered and update on `clk` rising edges only.
- `shot_done` in cycle N: `is_scored` and `score` are visible in N+1.
- Display hold: `game_state` changes in cycle N+1+`HOLD_CYCLES`; `is_scored` drops in that same cycle.
- Start edge: `start_btn` rising in cycle N (with low in N-1) → state change in N+1.
- Simultaneous `shot_done` and hold expiry: impossible by construction, since `shot_done` is ignored while holding.
- Reset deasserted mid-match: the block returns to START on the first edge after release; no partial state survives.

## Configuration
- `SUDDEN_DEATH_EN` defined:
  - A tie at or after round `ROUNDS` continues play: `round_counter` += 1, go to SHOOTER.
  - If `round_counter` = 15 with a tie, go to LOOSER; the counter never wraps.
- `SUDDEN_DEATH_EN` undefined:
  - A tie after round `ROUNDS` goes directly to LOOSER.

## Test plan
Bench setup: `ROUNDS` = 2, `HOLD_CYCLES` = 4.
- Reset then idle: `game_state` = START, `score` = 0x00, `round_counter` = 0, `game_mode` = MULTI.
- `mode_sel` = 0, pulse `start_btn` → next cycle SHOOTER, `round_counter` = 1, `game_mode` = SOLO. Then `shot_done` with `shot_goal` = 1 → next cycle `score` = 0x10, `is_scored` = 1. Four cycles later: KEEPER, `is_scored` = 0.
- A second `shot_done` during the hold window → `score` unchanged at 0x10.
- Full match, player scores 2, opponent 1 → after the final hold, WINNER with `score` = 0x21, `round_counter` = 2. Start edge → START with `score` = 0x00.
- Tie 1–1 after 2 rounds:
  - Without `SUDDEN_DEATH_EN` → LOOSER.
  - With `SUDDEN_DEATH_EN` → SHOOTER, `round_counter` = 3.
- Assert `rst` low mid-hold in KEEPER → outputs reach reset values immediately without a clock edge; START after release.

Source files
------------

// File: rtl/control_if.sv
// Match-level control bundle from game_controller to the screen selector and drawing stages,
// together with the shared state/mode encodings.
package control_pkg;
    typedef enum logic [2:0] {
        START   = 3'd0,
        SHOOTER = 3'd1,
        KEEPER  = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } game_state_t;

    typedef enum logic {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } game_mode_t;
endpackage

interface control_if;
    control_pkg::game_state_t game_state;
    control_pkg::game_mode_t  game_mode;
    logic [7:0]               score;
    logic [3:0]               round_counter;
    logic                     is_scored;

    modport out    (output game_state, game_mode, score, round_counter, is_scored);
    modport master (output game_state, game_mode, score, round_counter, is_scored);
    modport slave  (input  game_state, game_mode, score, round_counter, is_scored);
endinterface

// File: rtl/game_controller.sv
// Penalty shoot-out match FSM: alternates shooter/keeper turns, scores, holds results, picks winner.
// Optional feature: define SUDDEN_DEATH_EN to continue tied matches past ROUNDS (up to round 15).
module game_controller
    import control_pkg::*;
#(
    parameter int ROUNDS      = 5,
    parameter int HOLD_CYCLES = 65_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       mode_sel,
    input  logic       shot_done,
    input  logic       shot_goal,
    control_if.out     out_control
);
    localparam int               CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(ROUNDS);

    game_state_t      state_reg;
    game_mode_t       mode_reg;
    logic [7:0]       score_reg;
    logic [3:0]       round_reg;
    logic             scored_reg;
    logic             hold_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             start_d_reg;

    logic       start_edge;
    logic [3:0] player_goals;
    logic [3:0] opp_goals;

    assign start_edge   = start_btn & ~start_d_reg;
    assign player_goals = score_reg[7:4];
    assign opp_goals    = score_reg[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= START;
            mode_reg     <= MULTI;
            score_reg    <= 8'h00;
            round_reg    <= 4'd0;
            scored_reg   <= 1'b0;
            hold_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            start_d_reg  <= 1'b0;
        end else begin
            start_d_reg <= start_btn;
            case (state_reg)
                START: begin
                    if (start_edge) begin
                        state_reg  <= SHOOTER;
                        round_reg  <= 4'd1;
                        score_reg  <= 8'h00;
                        scored_reg <= 1'b0;
                        hold_reg   <= 1'b0;
                        mode_reg   <= game_mode_t'(mode_sel);
                    end
                end
                SHOOTER, KEEPER: begin
                    if (hold_reg) begin
                        if (hold_cnt_reg != '0) begin
                            hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
                        end else begin
                            hold_reg   <= 1'b0;
                            scored_reg <= 1'b0;
                            if (state_reg == SHOOTER) begin
                                state_reg <= KEEPER;
                            end else if (round_reg < LAST_ROUND) begin
                                round_reg <= round_reg + 4'd1;
                                state_reg <= SHOOTER;
                            end else if (player_goals > opp_goals) begin
                                state_reg <= WINNER;
                            end else if (player_goals < opp_goals) begin
                                state_reg <= LOOSER;
                            end else begin
`ifdef SUDDEN_DEATH_EN
                                // Tie keeps playing until the 4-bit round counter is exhausted.
                                if (round_reg == 4'd15) begin
                                    state_reg <= LOOSER;
                                end else begin
                                    round_reg <= round_reg + 4'd1;
                                    state_reg <= SHOOTER;
                                end
`else
                                state_reg <= LOOSER;
`endif
                            end
                        end
                    end else if (shot_done) begin
                        scored_reg   <= shot_goal;
                        hold_reg     <= 1'b1;
                        hold_cnt_reg <= HOLD_LOAD;
                        if (shot_goal) begin
                            if (state_reg == SHOOTER) begin
                                if (player_goals != 4'hF) score_reg[7:4] <= player_goals + 4'd1;
                            end else begin
                                if (opp_goals != 4'hF) score_reg[3:0] <= opp_goals + 4'd1;
                            end
                        end
                    end
                end
                WINNER, LOOSER: begin
                    if (start_edge) begin
                        state_reg  <= START;
                        score_reg  <= 8'h00;
                        round_reg  <= 4'd0;
                        scored_reg <= 1'b0;
                    end
                end
                default: state_reg <= START;
            endcase
        end
    end

    assign out_control.game_state    = state_reg;
    assign out_control.game_mode     = mode_reg;
    assign out_control.score         = score_reg;
    assign out_control.round_counter = round_reg;
    assign out_control.is_scored     = scored_reg;
endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with ROUNDS=2, HOLD_CYCLES=4: vector table, hand sequences, random matches.
module tb_game_controller;
    import control_pkg::*;

    localparam int R = 2;
    localparam int H = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start_btn = 1'b0;
    logic mode_sel  = 1'b0;
    logic shot_done = 1'b0;
    logic shot_goal = 1'b0;

    control_if ctl();

    game_controller #(.ROUNDS(R), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start_btn  (start_btn),
        .mode_sel   (mode_sel),
        .shot_done  (shot_done),
        .shot_goal  (shot_goal),
        .out_control(ctl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the match, kept as plain counters
    game_state_t m_state = START;
    game_mode_t  m_mode  = MULTI;
    int          m_p     = 0;
    int          m_o     = 0;
    int          m_round = 0;

    typedef struct {
        logic        mode;
        logic [3:0]  kicks;   // {p1, o1, p2, o2}
        logic        spur;
        game_state_t exp_state;
        logic [7:0]  exp_score;
        int          exp_round;
    } vec_t;

    vec_t tbl[6];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(ctl.game_state), 32'(m_state));
        check({tag, "_score"}, 32'(ctl.score), 32'(m_p * 16 + m_o));
        check({tag, "_round"}, 32'(ctl.round_counter), 32'(m_round));
        check({tag, "_mode"},  32'(ctl.game_mode), 32'(m_mode));
    endtask

    task automatic press_start(input logic mode);
        mode_sel  = mode;
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        mode_sel  = 1'($urandom_range(1, 0));
        if (m_state == START) begin
            m_state = SHOOTER; m_round = 1; m_p = 0; m_o = 0;
            m_mode  = mode ? MULTI : SOLO;
        end else if (m_state == WINNER || m_state == LOOSER) begin
            m_state = START; m_round = 0; m_p = 0; m_o = 0;
        end
        check_all("start");
        check("start_scored", 32'(ctl.is_scored), 32'd0);
        step(1);
    endtask

    task automatic play_kick(input logic goal, input logic spur);
        logic player;
        player    = (m_state == SHOOTER);
        shot_goal = goal;
        shot_done = 1'b1;
        step(1);
        shot_done = 1'b0;
        shot_goal = 1'($urandom_range(1, 0));
        if (goal) begin
            if (player) m_p = (m_p == 15) ? 15 : m_p + 1;
            else        m_o = (m_o == 15) ? 15 : m_o + 1;
        end
        check_all("kick");
        check("kick_scored", 32'(ctl.is_scored), 32'(goal));
        if (spur) begin
            // another kick and a start press inside the hold window must both be ignored
            shot_done = 1'b1; shot_goal = 1'b1; start_btn = 1'b1;
            step(1);
            shot_done = 1'b0; start_btn = 1'b0;
            step(H - 2);
        end else begin
            step(H - 1);
        end
        check_all("hold");
        check("hold_scored", 32'(ctl.is_scored), 32'(goal));
        step(1);
        if (player) begin
            m_state = KEEPER;
        end else if (m_round < R) begin
            m_round++; m_state = SHOOTER;
        end else if (m_p > m_o) begin
            m_state = WINNER;
        end else if (m_p < m_o) begin
            m_state = LOOSER;
        end else begin
`ifdef SUDDEN_DEATH_EN
            if (m_round == 15) m_state = LOOSER;
            else begin m_round++; m_state = SHOOTER; end
`else
            m_state = LOOSER;
`endif
        end
        check_all("expiry");
        check("expiry_scored", 32'(ctl.is_scored), 32'd0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_state = START; m_mode = MULTI; m_p = 0; m_o = 0; m_round = 0;
        check_all("async_rst");
        check("async_rst_scored", 32'(ctl.is_scored), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check_all("post_rst");
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'b1011, 1'b1, WINNER, 8'h21, 2};
`ifdef SUDDEN_DEATH_EN
        tbl[1] = '{1'b1, 4'b1100, 1'b0, SHOOTER, 8'h11, 3};
        tbl[4] = '{1'b0, 4'b0000, 1'b0, SHOOTER, 8'h00, 3};
`else
        tbl[1] = '{1'b1, 4'b1100, 1'b0, LOOSER, 8'h11, 2};
        tbl[4] = '{1'b0, 4'b0000, 1'b0, LOOSER, 8'h00, 2};
`endif
        tbl[2] = '{1'b0, 4'b0100, 1'b0, LOOSER, 8'h01, 2};
        tbl[3] = '{1'b1, 4'b0010, 1'b0, WINNER, 8'h10, 2};
        tbl[5] = '{1'b1, 4'b0111, 1'b0, LOOSER, 8'h12, 2};

        // Reset then idle; kicks in START are ignored
        step(3);
        check_all("in_rst");
        rst_n = 1'b1;
        step(2);
        check_all("idle");
        shot_goal = 1'b1; shot_done = 1'b1;
        step(1);
        shot_done = 1'b0;
        step(1);
        check_all("start_ignores_kick");
        check("idle_scored", 32'(ctl.is_scored), 32'd0);

        for (int i = 0; i < 6; i++) begin
            press_start(tbl[i].mode);
            play_kick(tbl[i].kicks[3], tbl[i].spur);
            play_kick(tbl[i].kicks[2], 1'b0);
            play_kick(tbl[i].kicks[1], 1'b0);
            play_kick(tbl[i].kicks[0], 1'b0);
            check("tbl_state", 32'(ctl.game_state), 32'(tbl[i].exp_state));
            check("tbl_score", 32'(ctl.score), 32'(tbl[i].exp_score));
            check("tbl_round", 32'(ctl.round_counter), 32'(tbl[i].exp_round));
            if (m_state == WINNER || m_state == LOOSER) begin
                shot_goal = 1'b1; shot_done = 1'b1;
                step(1);
                shot_done = 1'b0;
                step(1);
                check_all("frozen");
                press_start(1'b0);
            end else begin
                do_reset();
            end
        end

        // Reset asserted in the middle of a KEEPER hold
        press_start(1'b1);
        play_kick(1'b1, 1'b0);
        shot_goal = 1'b1; shot_done = 1'b1;
        step(1);
        shot_done = 1'b0;
        m_o = 1;
        check_all("keeper_goal");
        check("keeper_scored", 32'(ctl.is_scored), 32'd1);
        do_reset();

`ifdef SUDDEN_DEATH_EN
        // Endless tie stops at round 15
        press_start(1'b0);
        for (int k = 0; k < 40 && (m_state == SHOOTER || m_state == KEEPER); k++)
            play_kick(1'b0, 1'b0);
        check("sd_cap_state", 32'(ctl.game_state), 32'(LOOSER));
        check("sd_cap_round", 32'(ctl.round_counter), 32'd15);
        press_start(1'b0);
`endif

        for (int m = 0; m < 12; m++) begin
            press_start(1'($urandom_range(1, 0)));
            for (int k = 0; k < 40 && (m_state == SHOOTER || m_state == KEEPER); k++)
                play_kick(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
            check("rand_done", 32'(ctl.game_state == WINNER || ctl.game_state == LOOSER), 32'd1);
            press_start(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
